// File: rtl/kim_keypad_emu.sv
// kim_keypad_emu: answers the KIM-1 row scan by pulling one KB_COL low for a host-requested key.
// Define KEYPAD_SCAN_COUNT_EN to end PRESS after SCAN_HOLD row-scan edges (with a 4*HOLD_CYCLES timeout).
module kim_keypad_emu #(
  parameter int HOLD_CYCLES    = 50000,
  parameter int RELEASE_CYCLES = 50000,
  parameter int SCAN_HOLD      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic       key_ready,
  output logic       key_err,
  output logic       key_busy,
  input  logic [3:0] kb_row,
  output logic [6:0] kb_col
);
  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;
`ifdef KEYPAD_SCAN_COUNT_EN
  localparam int CW = 22;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(4 * HOLD_CYCLES);
`else
  localparam int CW = 20;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] row_q, row_d, row_n;
  logic [2:0] col_q, col_d, col_n;
  logic [6:0] kb_col_q, kb_col_d;
  logic err_q, err_d;
  logic accept, press_done, unused_row;
  assign unused_row = kb_row[3];
  assign row_n  = key_code < 5'd7 ? 2'd0 : key_code < 5'd14 ? 2'd1 : 2'd2;
  assign col_n  = 3'(key_code - (key_code < 5'd7 ? 5'd0 : key_code < 5'd14 ? 5'd7 : 5'd14));
  assign accept = key_valid && state_q == IDLE && key_code <= 5'h14;
`ifdef KEYPAD_SCAN_COUNT_EN
  logic [3:0] row_prev_q;
  logic [7:0] scan_q, scan_d;
  logic fall;
  assign fall       = row_prev_q[row_q] && !kb_row[row_q];
  assign press_done = cnt_q == CW'(1) || (fall && scan_q == 8'(SCAN_HOLD - 1));
  assign scan_d     = state_q != PRESS ? 8'd0 : scan_q + 8'(fall);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      row_prev_q <= 4'hF;
      scan_q     <= 8'd0;
    end else begin
      row_prev_q <= kb_row;
      scan_q     <= scan_d;
    end
`else
  assign press_done = cnt_q == CW'(1);
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    if (accept) begin
      state_d = PRESS;
      cnt_d   = HOLD_LOAD;
      row_d   = row_n;
      col_d   = col_n;
    end else if (state_q == PRESS) begin
      state_d = press_done ? RELEASE : PRESS;
      cnt_d   = press_done ? CW'(RELEASE_CYCLES) : cnt_q - CW'(1);
    end else if (state_q == RELEASE) begin
      state_d = cnt_q == CW'(1) ? IDLE : RELEASE;
      cnt_d   = cnt_q - CW'(1);
    end
    err_d    = key_valid && state_q == IDLE && key_code > 5'h14;
    // the column only answers while PRESS continues, so the exit cycle already reads released
    kb_col_d = (state_q == PRESS && state_d == PRESS && !kb_row[row_q]) ? ~(7'd1 << col_q) : 7'h7F;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      row_q    <= 2'd0;
      col_q    <= 3'd0;
      kb_col_q <= 7'h7F;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      kb_col_q <= kb_col_d;
      err_q    <= err_d;
    end
  assign key_ready = state_q == IDLE;
  assign key_busy  = state_q == PRESS;
  assign key_err   = err_q;
  assign kb_col    = kb_col_q;
endmodule

// File: tb/tb_kim_keypad_emu.sv
// tb_kim_keypad_emu: directed vector table plus hand sequences for timing, busy rejection and async reset.
module tb_kim_keypad_emu;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [4:0] key_code = 5'd0;
  logic       key_ready, key_err, key_busy;
  logic [3:0] kb_row = 4'hF;
  logic [6:0] kb_col;
  int passed = 0;
  int total = 0;

  kim_keypad_emu #(.HOLD_CYCLES(10), .RELEASE_CYCLES(5), .SCAN_HOLD(8)) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .key_err(key_err), .key_busy(key_busy),
    .kb_row(kb_row), .kb_col(kb_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] code;
    logic [3:0] row;
    logic [6:0] col;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && !key_ready; i++) tick();
    chk("idle_timeout", key_ready, 1);
  endtask

  task automatic accept(input logic [4:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
  endtask

  initial begin
    vec_t v[11];
    v[0]  = '{5'h05, 4'b1110, 7'b1011111};
    v[1]  = '{5'h13, 4'b1011, 7'b1011111};
    v[2]  = '{5'h13, 4'b1000, 7'b1011111};
    v[3]  = '{5'h00, 4'b1110, 7'b1111110};
    v[4]  = '{5'h07, 4'b1101, 7'b1111110};
    v[5]  = '{5'h0D, 4'b1101, 7'b0111111};
    v[6]  = '{5'h14, 4'b1011, 7'b0111111};
    v[7]  = '{5'h0E, 4'b1011, 7'b1111110};
    v[8]  = '{5'h05, 4'b1101, 7'h7F};
    v[9]  = '{5'h14, 4'b1110, 7'h7F};
    v[10] = '{5'h08, 4'b0111, 7'h7F};

    tick();
    tick();
    chk("rst_col", kb_col, 7'h7F);
    chk("rst_ready", key_ready, 1);
    chk("rst_err", key_err, 0);
    chk("rst_busy", key_busy, 0);
    #4 reset_n = 1'b1;
    tick();

    foreach (v[k]) begin
      kb_row = 4'hF;
      accept(v[k].code);
      chk($sformatf("ready_low_%0d", k), key_ready, 0);
      kb_row = v[k].row;
      tick();
      chk($sformatf("col_%0d", k), kb_col, v[k].col);
      chk($sformatf("busy_%0d", k), key_busy, 1);
      kb_row = 4'hF;
      wait_idle();
    end

    kb_row = 4'hF;
    accept(5'h05);
    kb_row = 4'b1110;
    tick();
    chk("d5_low", kb_col, 7'b1011111);
    kb_row = 4'b1101;
    tick();
    chk("d5_other_row", kb_col, 7'h7F);
    kb_row = 4'hF;
    wait_idle();

    accept(5'h15);
    chk("err_pulse", key_err, 1);
    chk("err_ready", key_ready, 1);
    chk("err_col", kb_col, 7'h7F);
    tick();
    chk("err_clear", key_err, 0);
    chk("err_col2", kb_col, 7'h7F);
    accept(5'h1F);
    chk("err_1f", key_err, 1);
    chk("err_1f_busy", key_busy, 0);
    tick();
    chk("err_1f_clear", key_err, 0);

    kb_row = 4'b1110;
    accept(5'h00);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t_busy_%0d", i), key_busy, i <= 9);
      chk($sformatf("t_ready_%0d", i), key_ready, i >= 15);
      chk($sformatf("t_col_%0d", i), kb_col, (i >= 1 && i <= 9) ? 7'b1111110 : 7'h7F);
      chk($sformatf("t_err_%0d", i), key_err, 0);
      key_valid = (i == 2 || i == 3);
      key_code  = 5'h01;
      tick();
    end
    key_valid = 1'b0;
    kb_row = 4'hF;
    tick();
    chk("t_no_second", key_busy, 0);

    kb_row = 4'b1110;
    accept(5'h00);
    tick();
    chk("mid_col_low", kb_col, 7'b1111110);
    #2 reset_n = 1'b0;
    #1;
    chk("async_col", kb_col, 7'h7F);
    chk("async_ready", key_ready, 1);
    chk("async_busy", key_busy, 0);
    #1 reset_n = 1'b1;
    tick();
    chk("post_rst_ready", key_ready, 1);
    chk("post_rst_col", kb_col, 7'h7F);
    kb_row = 4'hF;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/kim_keypad_emu.md
Name: kim_keypad_emu

Overview:
Keypad responder for the KIM-1 keyboard matrix. It answers the KIM's row scan, which drives KB_ROW open-collector and active-low, by pulling one KB_COL line low. This lets a host-side source inject key presses with no physical keypad: a UART bridge, a test bench, or a script ROM. It sits between the core's KB_ROW/KB_COL pins and that host, and presents a press/hold/release sequence timed so the monitor's debounce accepts exactly one key per request.

Parameters:
HOLD_CYCLES, 50000, clk cycles the key is held pressed (50 ms at 1 MHz); legal range 1..2^20-1.
RELEASE_CYCLES, 50000, clk cycles of forced release after each press; legal range 1..2^20-1.
SCAN_HOLD, 8, row-scan events required to end a press (used only with KEYPAD_SCAN_COUNT_EN); legal range 1..255.

Ports:
clk  in  1  KIM 1 MHz system clock; single clock domain.
reset_n  in  1  asynchronous, active-low reset.
key_valid  in  1  host request; a code is accepted on a clk edge where key_valid && key_ready.
key_code  in  5  KIM key code: 0x00-0x0F hex digits, 0x10 AD, 0x11 DA, 0x12 +, 0x13 GO, 0x14 PC.
key_ready  out  1  block idle, will accept a request.
key_err  out  1  one-cycle pulse when a code above 0x14 is presented with key_valid && key_ready.
key_busy  out  1  high in PRESS state.
kb_row  in  4  KB_ROW pin levels, active low; only bits 2:0 are decoded, bit 3 is ignored.
kb_col  out  7  KB_COL drive, active low; 1 means released.

Behaviour:
- Reset, asynchronous: state=IDLE, kb_col=7'h7F, key_ready=1, key_err=0, key_busy=0, counters cleared. If reset_n asserts mid-PRESS, kb_col returns to 7'h7F immediately, without waiting for clk.
- Decode: row = code/7, col = code%7, done by registered lookup at accept.
  - Row 0: codes 0x00-0x06.
  - Row 1: codes 0x07-0x0D.
  - Row 2: codes 0x0E-0x14.
- FSM states: IDLE, PRESS, RELEASE.
- IDLE:
  - key_ready=1.
  - Valid code accepted: latch row/col, load hold counter, go to PRESS.
  - Invalid code: pulse key_err for one cycle, stay in IDLE, kb_col unchanged.
- PRESS:
  - key_ready=0, key_busy=1.
  - kb_col[col]=0 in the cycle after any clk edge where kb_row[row]==0; otherwise kb_col=7'h7F. This is a one-cycle registered response.
  - Other rows low at the same time do not matter; only the latched row is examined.
  - Lasts exactly HOLD_CYCLES cycles, then go to RELEASE.
- RELEASE:
  - kb_col=7'h7F, key_ready=0, key_busy=0.
  - Lasts exactly RELEASE_CYCLES cycles, then go to IDLE.
- Latency: key_ready is low for exactly HOLD_CYCLES+RELEASE_CYCLES cycles, starting the cycle after the accept edge.
- Requests presented while key_ready=0 are ignored. They are not queued and key_err is not pulsed.
- Counters are 20-bit down-counters with no wrap. Terminal count is 1, so a parameter value of 1 gives a one-cycle state.
- kb_col bits other than the latched col are always 1.

Optional Feature:
KEYPAD_SCAN_COUNT_EN:
- Defined: PRESS ends after SCAN_HOLD falling edges of kb_row[row], instead of after HOLD_CYCLES. Edges are detected against a registered copy of kb_row. There is also a timeout: if 4*HOLD_CYCLES cycles pass without reaching the count, PRESS still ends. RELEASE is unchanged. An 8-bit scan counter is added.
- Undefined: PRESS is purely time-based, and no edge detector or scan counter is instantiated.

Test Plan:
1. Reset: assert reset_n=0 -> kb_col=7'h7F, key_ready=1, key_err=0, key_busy=0.
2. Digit 5: key_code=0x05 accepted; drive kb_row=4'b1110 -> kb_col=7'b1011111 one cycle later; drive kb_row=4'b1101 -> kb_col=7'h7F next cycle.
3. GO key: key_code=0x13 accepted; kb_row=4'b1011 -> kb_col=7'b1011111 (col 5); kb_row=4'b1000 -> col 5 still low; kb_row=4'b1111 -> 7'h7F.
4. Invalid code: key_code=0x15 with key_valid=1 -> key_err high for exactly 1 cycle, key_ready stays 1, kb_col=7'h7F throughout.
5. Timing and busy rejection: HOLD_CYCLES=10, RELEASE_CYCLES=5, accept code 0x00 -> key_busy high 10 cycles, key_ready low 15 cycles. A second key_valid (0x01) at cycle 3 is ignored and never appears on kb_col.
6. Reset mid-press: reset_n=0 during PRESS with kb_row[0] low -> kb_col=7'h7F asynchronously. After release of reset_n: IDLE, key_ready=1.
